// File: rtl/bky_load_ctrl.sv
// bky_load_ctrl: sequences FIFO word reads and per-word shift bursts for one load.
// State updates on the falling edge of CLK; RST is asynchronous and active-high.
module bky_load_ctrl #(
   parameter  int WORD_BITS = 16,
   parameter  int NWORDS    = 19,
   parameter  int WAIT_MAX  = 255,
   localparam int WW = (NWORDS    > 1) ? $clog2(NWORDS)    : 1,
   localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1,
   localparam int TW = (WAIT_MAX  > 1) ? $clog2(WAIT_MAX)  : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          ABORT,
   input  logic          MT,
   output logic          RDENA,
   output logic          SHFT_ENA,
   output logic          CLR_CNT,
   output logic          SET_DONE,
   output logic          BUSY,
   output logic          TIMEOUT_ERR,
   output logic [WW-1:0] WORD_IDX,
   output logic [BW-1:0] BIT_IDX
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT4DATA,
      S_READ,
      S_SHIFT,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_BITS - 1);
   localparam logic [WW-1:0] WORD_LAST  = WW'(NWORDS - 1);
   localparam logic [TW-1:0] WAIT_LAST  = TW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam bit            TIMEOUT_EN = (WAIT_MAX != 0);

   state_t          state, nextstate;
   logic [BW-1:0]   bit_cnt, bit_cnt_n;
   logic [WW-1:0]   word_cnt, word_cnt_n;
   logic [TW-1:0]   wait_cnt, wait_cnt_n;
   logic            bit_last, word_last, clr_n;

   assign bit_last  = (bit_cnt == BIT_LAST);
   assign word_last = (word_cnt == WORD_LAST);

   always_comb begin
      nextstate = state;
      case (state)
         S_IDLE:
            if (START) nextstate = S_WAIT4DATA;
         S_WAIT4DATA:
            if (ABORT)                                     nextstate = S_IDLE;
            else if (!MT)                                  nextstate = S_READ;
            else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) nextstate = S_ERROR;
         S_READ:
            nextstate = ABORT ? S_IDLE : S_SHIFT;
         S_SHIFT:
            if (ABORT)          nextstate = S_IDLE;
            else if (!bit_last) nextstate = S_SHIFT;
            else if (word_last) nextstate = S_DONE;
            else if (!MT)       nextstate = S_READ;
            else                nextstate = S_WAIT4DATA;
         S_DONE, S_ERROR:
            if (!START) nextstate = S_IDLE;
         default:
            nextstate = S_IDLE;
      endcase
   end

   // word_cnt also clears whenever IDLE is entered so an aborted load leaves WORD_IDX at 0.
   always_comb begin
      bit_cnt_n  = '0;
      word_cnt_n = word_cnt;
      wait_cnt_n = '0;
      clr_n      = (state == S_IDLE) && (nextstate == S_WAIT4DATA);
      if ((state == S_SHIFT) && (nextstate == S_SHIFT))
         bit_cnt_n = bit_cnt + 1'b1;
      if ((nextstate == S_IDLE) || (state == S_IDLE))
         word_cnt_n = '0;
      else if ((state == S_SHIFT) && bit_last &&
               ((nextstate == S_READ) || (nextstate == S_WAIT4DATA)))
         word_cnt_n = word_cnt + 1'b1;
      if ((state == S_WAIT4DATA) && (nextstate == S_WAIT4DATA))
         wait_cnt_n = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
   end

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         wait_cnt    <= '0;
         RDENA       <= 1'b0;
         SHFT_ENA    <= 1'b0;
         CLR_CNT     <= 1'b0;
         SET_DONE    <= 1'b0;
         BUSY        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         state       <= nextstate;
         bit_cnt     <= bit_cnt_n;
         word_cnt    <= word_cnt_n;
         wait_cnt    <= wait_cnt_n;
         RDENA       <= (nextstate == S_READ);
         SHFT_ENA    <= (nextstate == S_SHIFT);
         CLR_CNT     <= clr_n;
         SET_DONE    <= (nextstate == S_DONE);
         BUSY        <= (nextstate == S_WAIT4DATA) || (nextstate == S_READ) ||
                        (nextstate == S_SHIFT);
         TIMEOUT_ERR <= (nextstate == S_ERROR);
      end
   end

   assign WORD_IDX = word_cnt;
   assign BIT_IDX  = bit_cnt;

endmodule

// File: tb/tb_bky_load_ctrl.sv
// Directed bench for bky_load_ctrl: defaults, timeout and minimum-size instances.
module tb_bky_load_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic ABORT = 1'b0;

   logic START = 1'b0, MT = 1'b0;
   logic rdena, shft_ena, clr_cnt, set_done, busy, timeout_err;
   logic [4:0] word_idx;
   logic [3:0] bit_idx;

   logic to_start = 1'b0, to_mt = 1'b1;
   logic to_rdena, to_shft_ena, to_clr_cnt, to_set_done, to_busy, to_timeout_err;
   logic [4:0] to_word_idx;
   logic [3:0] to_bit_idx;

   logic mn_start = 1'b0, mn_mt = 1'b0;
   logic mn_rdena, mn_shft_ena, mn_clr_cnt, mn_set_done, mn_busy, mn_timeout_err;
   logic mn_word_idx, mn_bit_idx;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   bky_load_ctrl u_dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MT(MT),
      .RDENA(rdena), .SHFT_ENA(shft_ena), .CLR_CNT(clr_cnt), .SET_DONE(set_done),
      .BUSY(busy), .TIMEOUT_ERR(timeout_err), .WORD_IDX(word_idx), .BIT_IDX(bit_idx)
   );

   bky_load_ctrl #(.WAIT_MAX(8)) u_to (
      .CLK(CLK), .RST(RST), .START(to_start), .ABORT(ABORT), .MT(to_mt),
      .RDENA(to_rdena), .SHFT_ENA(to_shft_ena), .CLR_CNT(to_clr_cnt),
      .SET_DONE(to_set_done), .BUSY(to_busy), .TIMEOUT_ERR(to_timeout_err),
      .WORD_IDX(to_word_idx), .BIT_IDX(to_bit_idx)
   );

   bky_load_ctrl #(.WORD_BITS(1), .NWORDS(1)) u_min (
      .CLK(CLK), .RST(RST), .START(mn_start), .ABORT(ABORT), .MT(mn_mt),
      .RDENA(mn_rdena), .SHFT_ENA(mn_shft_ena), .CLR_CNT(mn_clr_cnt),
      .SET_DONE(mn_set_done), .BUSY(mn_busy), .TIMEOUT_ERR(mn_timeout_err),
      .WORD_IDX(mn_word_idx), .BIT_IDX(mn_bit_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {17'd0, rdena, shft_ena, clr_cnt, set_done, busy, timeout_err, word_idx, bit_idx};
   endfunction

   // Runs a default load with MT=0 from the next falling edge; edge n observed at posedge n.
   task automatic run_load(output int clr, output int rd, output int sh, output int de,
                           output logic [3:0] s1, output logic [3:0] b18,
                           output logic [5:0] s19);
      clr = 0; rd = 0; sh = 0; de = 0; s1 = '0; b18 = '0; s19 = '0;
      START = 1'b1;
      for (int n = 1; n <= 340; n++) begin
         @(posedge CLK);
         clr += int'(clr_cnt);
         rd  += int'(rdena);
         sh  += int'(shft_ena);
         if (set_done && de == 0) de = n;
         if (n == 1)  s1  = {busy, clr_cnt, rdena, shft_ena};
         if (n == 18) b18 = bit_idx;
         if (n == 19) s19 = {rdena, word_idx};
      end
   endtask

   initial begin
      int clr, rd, sh, de, bad_rd, bad_busy, bad_word, done_seen, to_rd;
      int mt_left;
      bit trig, found;
      logic [3:0] s1, b18;
      logic [5:0] s19;
      logic [1:0] to8, to9;
      logic [3:0] mn_obs;
      logic [3:0] mn_exp [5];
      mn_exp = '{4'b1000, 4'b1100, 4'b1010, 4'b0001, 4'b0001};

      // reset and quiet-after-reset
      @(posedge CLK);
      check("reset_outs", outs(), 32'd0);
      @(posedge CLK);
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      check("idle_no_start", outs(), 32'd0);

      // full default load
      run_load(clr, rd, sh, de, s1, b18, s19);
      check("first_edge_busy_clr", 32'(s1), 32'h0000_000C);
      check("edge18_bit15", 32'(b18), 32'd15);
      check("edge19_read_word1", 32'(s19), 32'h0000_0021);
      check("clr_pulses", 32'(clr), 32'd1);
      check("rdena_pulses", 32'(rd), 32'd19);
      check("shift_cycles", 32'(sh), 32'd304);
      check("done_edge", 32'(de), 32'd325);
      check("done_hold_outs", {26'd0, set_done, busy, word_idx}, 32'h0000_0052);
      START = 1'b0;
      @(posedge CLK);
      check("done_clears", 32'(set_done), 32'd0);

      // MT stall between words
      bad_rd = 0; bad_busy = 0; bad_word = 0; mt_left = 0; trig = 0;
      rd = 0; sh = 0; de = 0;
      START = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge CLK);
         rd += int'(rdena);
         sh += int'(shft_ena);
         if (set_done && de == 0) de = n;
         if (mt_left > 0) begin
            if (rdena) bad_rd++;
            if (!busy) bad_busy++;
            if (word_idx != 5'd3) bad_word++;
            mt_left--;
            if (mt_left == 0) MT = 1'b0;
         end else if (!trig && shft_ena && word_idx == 5'd2 && bit_idx == 4'd15) begin
            trig = 1'b1;
            MT = 1'b1;
            mt_left = 10;
         end
      end
      check("stall_triggered", 32'(trig), 32'd1);
      check("stall_no_rdena", 32'(bad_rd), 32'd0);
      check("stall_busy", 32'(bad_busy), 32'd0);
      check("stall_word_idx", 32'(bad_word), 32'd0);
      check("stall_shift_cycles", 32'(sh), 32'd304);
      check("stall_rdena_pulses", 32'(rd), 32'd19);
      check("stall_done_edge", 32'(de), 32'd335);
      START = 1'b0;
      @(posedge CLK);

      // ABORT at bit 5 of word 2
      found = 0; done_seen = 0;
      START = 1'b1;
      for (int n = 1; n <= 200 && !found; n++) begin
         @(posedge CLK);
         done_seen += int'(set_done);
         if (shft_ena && word_idx == 5'd2 && bit_idx == 4'd5) found = 1'b1;
      end
      check("abort_point_found", 32'(found), 32'd1);
      ABORT = 1'b1;
      @(posedge CLK);
      check("abort_outs_zero", outs(), 32'd0);
      ABORT = 1'b0;
      START = 1'b0;
      repeat (30) begin
         @(posedge CLK);
         done_seen += int'(set_done);
      end
      check("abort_no_done", 32'(done_seen), 32'd0);

      // asynchronous reset mid-SHIFT, then a clean full load
      found = 0;
      START = 1'b1;
      for (int n = 1; n <= 200 && !found; n++) begin
         @(posedge CLK);
         if (shft_ena && word_idx == 5'd1 && bit_idx == 4'd7) found = 1'b1;
      end
      check("rst_point_found", 32'(found), 32'd1);
      #2 RST = 1'b1;
      #1 check("async_rst_outs", outs(), 32'd0);
      @(posedge CLK);
      RST = 1'b0;
      run_load(clr, rd, sh, de, s1, b18, s19);
      check("post_rst_rdena", 32'(rd), 32'd19);
      check("post_rst_shift", 32'(sh), 32'd304);
      check("post_rst_done_edge", 32'(de), 32'd325);
      START = 1'b0;
      @(posedge CLK);

      // data-wait timeout with WAIT_MAX=8
      to_rd = 0; to8 = '0; to9 = '0;
      to_start = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge CLK);
         to_rd += int'(to_rdena);
         if (n == 8) to8 = {to_busy, to_timeout_err};
         if (n == 9) to9 = {to_busy, to_timeout_err};
      end
      check("to_edge8_waiting", 32'(to8), 32'd2);
      check("to_edge9_error", 32'(to9), 32'd1);
      check("to_error_held", 32'(to_timeout_err), 32'd1);
      check("to_no_rdena", 32'(to_rd), 32'd0);
      to_start = 1'b0;
      @(posedge CLK);
      check("to_clears", 32'(to_timeout_err), 32'd0);

      // WORD_BITS=1, NWORDS=1
      mn_start = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge CLK);
         mn_obs = {mn_busy, mn_rdena, mn_shft_ena, mn_set_done};
         check($sformatf("min_seq_%0d", n + 1), 32'(mn_obs), 32'(mn_exp[n]));
      end
      ABORT = 1'b1;
      @(posedge CLK);
      check("min_abort_ignored_done", 32'(mn_set_done), 32'd1);
      ABORT = 1'b0;
      mn_start = 1'b0;
      @(posedge CLK);
      check("min_done_clears", 32'(mn_set_done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
